sdhost_cmd_engine: RTL and testbench

Parametrised SD-host command-line engine. It accepts a latched command (index, argument, response type, check enables) from the host register file and serialises a 48-bit CMD frame with CRC7 onto the CMD pin. It then waits for and deserialises the card response, checks it, and presents the result to the response register with a valid/ack handshake. The engine runs on the system clock and advances one SD bit per `sd_clk_en` strobe.

---
 rtl/sdhost_pkg.sv | 32 +++
 rtl/sdhost_cmd_engine_if.sv | 38 +++
 rtl/sdhost_crc7.sv | 24 ++
 rtl/sdhost_cmd_engine.sv | 209 ++++++++++++++++++++
 tb/tb_sdhost_cmd_engine.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sdhost_pkg.sv
// Shared constants, types and the CRC7 step function for the SD-host command engine.
package sdhost_pkg;

  // Response type codes as presented by the host register file
  localparam logic [1:0] RESP_NONE = 2'b00;
  localparam logic [1:0] RESP_R2   = 2'b01;
  localparam logic [1:0] RESP_48   = 2'b10;
  localparam logic [1:0] RESP_R3   = 2'b11;

  // CMD-line polynomial x^7 + x^3 + 1 (the x^7 term is implicit)
  localparam logic [6:0] CRC7_POLY = 7'h09;

  localparam int CMD_FRAME_LEN = 48;
  localparam int R2_FRAME_LEN  = 136;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEND  = 3'd1,
    WAIT  = 3'd2,
    RECV  = 3'd3,
    CHECK = 3'd4,
    DONE  = 3'd5
  } state_e;

  // One serial CRC7 step, MSB-first data
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sdhost_cmd_engine_if.sv
// Host-register-file side of the command engine: command request, response
// payload with valid/ack, completion level and error flags.
interface sdhost_cmd_engine_if
  import sdhost_pkg::*;
#(
  parameter int RESP_W = 128
) ();
  logic              start;
  logic [5:0]        cmd_index;
  logic [31:0]       cmd_argument;
  logic [1:0]        resp_type;
  logic              index_chk_en;
  logic              crc_chk_en;
  logic              busy;
  logic [RESP_W-1:0] response;
  logic              enable_response;
  logic              ack_response;
  logic              command_complete;
  logic              ack_command_complete;
  logic              err_timeout;
  logic              err_crc;
  logic              err_index;
  logic              err_endbit;

  modport master (
    output start, cmd_index, cmd_argument, resp_type, index_chk_en, crc_chk_en,
    output ack_response, ack_command_complete,
    input  busy, response, enable_response, command_complete,
    input  err_timeout, err_crc, err_index, err_endbit
  );

  modport slave (
    input  start, cmd_index, cmd_argument, resp_type, index_chk_en, crc_chk_en,
    input  ack_response, ack_command_complete,
    output busy, response, enable_response, command_complete,
    output err_timeout, err_crc, err_index, err_endbit
  );
endinterface

// File: rtl/sdhost_crc7.sv
// Serial CRC7 accumulator; shared by the transmit and receive paths.
module sdhost_crc7
  import sdhost_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic       din,
  output logic [6:0] crc
);

  // Accumulate one bit per enable; clear has priority over enable
  always_ff @(posedge clock) begin
    if (reset) begin
      crc <= 7'h00;
    end else if (clear) begin
      crc <= 7'h00;
    end else if (enable) begin
      crc <= crc7_step(crc, din);
    end
  end

endmodule

// File: rtl/sdhost_cmd_engine.sv
// SD-host CMD-line engine: serialises a 48-bit command with CRC7, then
// waits for, deserialises and checks the card response.
module sdhost_cmd_engine
  import sdhost_pkg::*;
#(
  parameter int TIMEOUT_BITS = 64,
  parameter int TO_W         = 8,
  parameter int RESP_W       = 128
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                sd_clk_en,
  input  logic                cmd_pin_in,
  output logic                cmd_pin_out,
  output logic                cmd_oe,
  sdhost_cmd_engine_if.slave  host
);

  state_e            state_r;
  logic [5:0]        idx_r;
  logic [1:0]        type_r;
  logic              ichk_r;
  logic              cchk_r;
  logic [47:0]       tx_shift_r;
  logic [127:0]      rx_shift_r;
  logic [7:0]        bit_cnt_r;
  logic [TO_W-1:0]   to_cnt_r;
  logic              busy_r;
  logic [RESP_W-1:0] response_r;
  logic              resp_valid_r;
  logic              cc_r;
  logic              err_timeout_r;
  logic              err_crc_r;
  logic              err_index_r;
  logic              err_endbit_r;

  logic [6:0]        crc_s;
  logic              crc_clr_s;
  logic              crc_en_s;
  logic              crc_din_s;
  logic [7:0]        last_bit_s;
  logic              rx_in_crc_s;

  sdhost_crc7 u_crc7 (
    .clock  (clock),
    .reset  (reset),
    .clear  (crc_clr_s),
    .enable (crc_en_s),
    .din    (crc_din_s),
    .crc    (crc_s)
  );

  // Receive framing: last bit index and whether the current bit is CRC-covered
  // (R2 excludes its first 8 bits; 48-bit frames include the start bit)
  always_comb begin
    last_bit_s  = (type_r == RESP_R2) ? 8'(R2_FRAME_LEN - 1) : 8'(CMD_FRAME_LEN - 1);
    rx_in_crc_s = (type_r == RESP_R2) ? ((bit_cnt_r >= 8'd8) && (bit_cnt_r < 8'd128))
                                      : (bit_cnt_r < 8'd40);
  end

  // CRC control: clear at command start and at end of transmit, feed TX/RX bits
  always_comb begin
    crc_clr_s = 1'b0;
    crc_en_s  = 1'b0;
    crc_din_s = 1'b0;
    case (state_r)
      IDLE: crc_clr_s = host.start;
      SEND: begin
        crc_en_s  = sd_clk_en && (bit_cnt_r < 8'd40);
        crc_din_s = tx_shift_r[47];
        crc_clr_s = sd_clk_en && (bit_cnt_r == 8'(CMD_FRAME_LEN));
      end
      WAIT: begin
        crc_en_s  = sd_clk_en && !cmd_pin_in && (type_r != RESP_R2);
        crc_din_s = cmd_pin_in;
      end
      RECV: begin
        crc_en_s  = sd_clk_en && rx_in_crc_s;
        crc_din_s = cmd_pin_in;
      end
      default: crc_clr_s = 1'b0;
    endcase
  end

  // Main FSM with all outputs registered
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r       <= IDLE;
      idx_r         <= 6'd0;
      type_r        <= RESP_NONE;
      ichk_r        <= 1'b0;
      cchk_r        <= 1'b0;
      tx_shift_r    <= 48'd0;
      rx_shift_r    <= 128'd0;
      bit_cnt_r     <= 8'd0;
      to_cnt_r      <= '0;
      busy_r        <= 1'b0;
      cmd_pin_out   <= 1'b1;
      cmd_oe        <= 1'b0;
      response_r    <= '0;
      resp_valid_r  <= 1'b0;
      cc_r          <= 1'b0;
      err_timeout_r <= 1'b0;
      err_crc_r     <= 1'b0;
      err_index_r   <= 1'b0;
      err_endbit_r  <= 1'b0;
    end else begin
      if (host.ack_response) begin
        resp_valid_r <= 1'b0;
      end
      if (host.ack_command_complete) begin
        cc_r          <= 1'b0;
        err_timeout_r <= 1'b0;
        err_crc_r     <= 1'b0;
        err_index_r   <= 1'b0;
        err_endbit_r  <= 1'b0;
      end
      case (state_r)
        IDLE: begin
          if (host.start) begin
            idx_r         <= host.cmd_index;
            type_r        <= host.resp_type;
            ichk_r        <= host.index_chk_en;
            cchk_r        <= host.crc_chk_en;
            tx_shift_r    <= {1'b0, 1'b1, host.cmd_index, host.cmd_argument, 7'h00, 1'b1};
            bit_cnt_r     <= 8'd0;
            busy_r        <= 1'b1;
            cc_r          <= 1'b0;
            err_timeout_r <= 1'b0;
            err_crc_r     <= 1'b0;
            err_index_r   <= 1'b0;
            err_endbit_r  <= 1'b0;
            state_r       <= SEND;
          end
        end
        SEND: begin
          if (sd_clk_en) begin
            if (bit_cnt_r == 8'(CMD_FRAME_LEN)) begin
              cmd_oe      <= 1'b0;
              cmd_pin_out <= 1'b1;
              bit_cnt_r   <= 8'd0;
              to_cnt_r    <= '0;
              state_r     <= (type_r == RESP_NONE) ? DONE : WAIT;
            end else begin
              cmd_oe    <= 1'b1;
              bit_cnt_r <= bit_cnt_r + 8'd1;
              if (bit_cnt_r == 8'd40) begin
                // CRC is final here; splice it in ahead of the end bit
                cmd_pin_out <= crc_s[6];
                tx_shift_r  <= {crc_s[5:0], 1'b1, 41'd0};
              end else begin
                cmd_pin_out <= tx_shift_r[47];
                tx_shift_r  <= {tx_shift_r[46:0], 1'b0};
              end
            end
          end
        end
        WAIT: begin
          if (sd_clk_en) begin
            if (!cmd_pin_in) begin
              rx_shift_r <= {rx_shift_r[126:0], 1'b0};
              bit_cnt_r  <= 8'd1;
              state_r    <= RECV;
            end else if (to_cnt_r == TO_W'(TIMEOUT_BITS - 1)) begin
              err_timeout_r <= 1'b1;
              state_r       <= DONE;
            end else begin
              to_cnt_r <= to_cnt_r + 1'b1;
            end
          end
        end
        RECV: begin
          if (sd_clk_en) begin
            rx_shift_r <= {rx_shift_r[126:0], cmd_pin_in};
            bit_cnt_r  <= bit_cnt_r + 8'd1;
            if (bit_cnt_r == last_bit_s) begin
              state_r <= CHECK;
            end
          end
        end
        CHECK: begin
          err_endbit_r <= !rx_shift_r[0];
          err_crc_r    <= cchk_r && (type_r != RESP_R3) && (rx_shift_r[7:1] != crc_s);
          err_index_r  <= ichk_r && (type_r == RESP_48) && (rx_shift_r[45:40] != idx_r);
          response_r   <= (type_r == RESP_R2) ? RESP_W'(rx_shift_r[127:8])
                                              : RESP_W'(rx_shift_r[39:8]);
          resp_valid_r <= 1'b1;
          state_r      <= DONE;
        end
        DONE: begin
          cc_r    <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign host.busy             = busy_r;
  assign host.response         = response_r;
  assign host.enable_response  = resp_valid_r;
  assign host.command_complete = cc_r;
  assign host.err_timeout      = err_timeout_r;
  assign host.err_crc          = err_crc_r;
  assign host.err_index        = err_index_r;
  assign host.err_endbit       = err_endbit_r;

endmodule

// File: tb/tb_sdhost_cmd_engine.sv
// Directed self-checking bench for sdhost_cmd_engine with hand-computed frames.
module tb_sdhost_cmd_engine;
  import sdhost_pkg::*;

  logic clock = 1'b0;
  logic reset;
  logic sd_clk_en;
  logic cmd_pin_in;
  logic cmd_pin_out;
  logic cmd_oe;

  int checks   = 0;
  int failures = 0;

  logic [47:0]  frame;
  logic         oe_ok;
  logic [119:0] r2_payload;
  logic [135:0] r2_frame;

  sdhost_cmd_engine_if #(.RESP_W(128)) hif ();

  sdhost_cmd_engine #(
    .TIMEOUT_BITS (64),
    .TO_W         (8),
    .RESP_W       (128)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .sd_clk_en   (sd_clk_en),
    .cmd_pin_in  (cmd_pin_in),
    .cmd_pin_out (cmd_pin_out),
    .cmd_oe      (cmd_oe),
    .host        (hif.slave)
  );

  always #5 clock = ~clock;

  task automatic check_value(input string tag, input logic [135:0] got, input logic [135:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clk1();
    @(posedge clock);
    #1;
  endtask

  // One SD bit period: three idle clocks then a strobe clock
  task automatic strobe_period();
    sd_clk_en = 1'b0;
    repeat (3) clk1();
    sd_clk_en = 1'b1;
    clk1();
    sd_clk_en = 1'b0;
  endtask

  task automatic errs(output logic [3:0] e);
    e = {hif.err_timeout, hif.err_crc, hif.err_index, hif.err_endbit};
  endtask

  // Issue a command, capture the 48 driven bits, then the release period
  task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
                          input logic ichk, input logic cchk,
                          output logic [47:0] frm, output logic ok);
    hif.cmd_index    = idx;
    hif.cmd_argument = arg;
    hif.resp_type    = rt;
    hif.index_chk_en = ichk;
    hif.crc_chk_en   = cchk;
    hif.start        = 1'b1;
    clk1();
    hif.start = 1'b0;
    frm = 48'd0;
    ok  = 1'b1;
    for (int i = 0; i < 48; i++) begin
      strobe_period();
      frm = {frm[46:0], cmd_pin_out};
      if (cmd_oe !== 1'b1) ok = 1'b0;
    end
    strobe_period();
  endtask

  // Card side: idle gap, then n bits MSB first
  task automatic card_reply(input logic [135:0] bits, input int n, input int gap);
    cmd_pin_in = 1'b1;
    for (int i = 0; i < gap; i++) strobe_period();
    for (int i = n - 1; i >= 0; i--) begin
      cmd_pin_in = bits[i];
      strobe_period();
    end
    cmd_pin_in = 1'b1;
  endtask

  task automatic ack_all();
    hif.ack_response         = 1'b1;
    hif.ack_command_complete = 1'b1;
    clk1();
    hif.ack_response         = 1'b0;
    hif.ack_command_complete = 1'b0;
  endtask

  logic [3:0] e;

  initial begin
    reset                    = 1'b1;
    sd_clk_en                = 1'b0;
    cmd_pin_in               = 1'b1;
    hif.start                = 1'b0;
    hif.cmd_index            = 6'd0;
    hif.cmd_argument         = 32'd0;
    hif.resp_type            = 2'b00;
    hif.index_chk_en         = 1'b0;
    hif.crc_chk_en           = 1'b0;
    hif.ack_response         = 1'b0;
    hif.ack_command_complete = 1'b0;
    repeat (3) clk1();

    // Reset state
    errs(e);
    check_value("rst_pin_out", 136'(cmd_pin_out), 136'd1);
    check_value("rst_oe", 136'(cmd_oe), 136'd0);
    check_value("rst_busy", 136'(hif.busy), 136'd0);
    check_value("rst_resp", 136'(hif.response), 136'd0);
    check_value("rst_valid", 136'(hif.enable_response), 136'd0);
    check_value("rst_cc", 136'(hif.command_complete), 136'd0);
    check_value("rst_errs", 136'(e), 136'd0);
    reset = 1'b0;
    clk1();

    // CMD0, no response
    send_cmd(6'd0, 32'h0000_0000, RESP_NONE, 1'b0, 1'b0, frame, oe_ok);
    check_value("cmd0_frame", 136'(frame), 136'h4000_0000_0095);
    check_value("cmd0_oe_held", 136'(oe_ok), 136'd1);
    check_value("cmd0_oe_released", 136'(cmd_oe), 136'd0);
    clk1();
    errs(e);
    check_value("cmd0_cc", 136'(hif.command_complete), 136'd1);
    check_value("cmd0_busy", 136'(hif.busy), 136'd0);
    check_value("cmd0_errs", 136'(e), 136'd0);
    check_value("cmd0_valid", 136'(hif.enable_response), 136'd0);
    ack_all();
    check_value("cmd0_cc_ack", 136'(hif.command_complete), 136'd0);

    // CMD8, R7 echo with its own CRC byte 0x13, after 5 idle bit times
    send_cmd(6'd8, 32'h0000_01AA, RESP_48, 1'b1, 1'b1, frame, oe_ok);
    check_value("cmd8_frame", 136'(frame), 136'h4800_0001_AA87);
    check_value("cmd8_crc_byte", 136'(frame[7:0]), 136'h87);
    card_reply(136'h0800_0001_AA13, 48, 5);
    clk1();
    check_value("cmd8_valid", 136'(hif.enable_response), 136'd1);
    check_value("cmd8_resp", 136'(hif.response), 136'h1AA);
    clk1();
    errs(e);
    check_value("cmd8_cc", 136'(hif.command_complete), 136'd1);
    check_value("cmd8_errs", 136'(e), 136'd0);
    hif.ack_response = 1'b1;
    clk1();
    hif.ack_response = 1'b0;
    check_value("cmd8_valid_ack", 136'(hif.enable_response), 136'd0);

    // CMD17 started while command_complete is still set; card answers index 18
    send_cmd(6'd17, 32'h0000_0000, RESP_48, 1'b1, 1'b1, frame, oe_ok);
    check_value("cmd17_cc_cleared", 136'(hif.command_complete), 136'd0);
    check_value("cmd17_frame", 136'(frame), 136'h5100_0000_0055);
    card_reply(136'h1200_0000_0075, 48, 2);
    repeat (2) clk1();
    errs(e);
    check_value("cmd17_errs", 136'(e), 136'b0010);
    check_value("cmd17_cc", 136'(hif.command_complete), 136'd1);
    hif.ack_response = 1'b1;
    clk1();
    hif.ack_response = 1'b0;

    // Timeout: no start bit; errors from CMD17 cleared by the new start
    send_cmd(6'd13, 32'h0000_0000, RESP_48, 1'b1, 1'b1, frame, oe_ok);
    errs(e);
    check_value("to_errs_cleared", 136'(e), 136'd0);
    check_value("to_busy", 136'(hif.busy), 136'd1);
    for (int i = 0; i < 63; i++) strobe_period();
    check_value("to_before_64", 136'(hif.err_timeout), 136'd0);
    strobe_period();
    check_value("to_at_64", 136'(hif.err_timeout), 136'd1);
    clk1();
    check_value("to_cc", 136'(hif.command_complete), 136'd1);
    check_value("to_valid", 136'(hif.enable_response), 136'd0);
    ack_all();

    // R2 with a corrupted CRC bit (correct CRC is 0x64)
    r2_payload = {1'b1, 103'd0, 16'h1234};
    r2_frame   = {8'h3F, r2_payload, 7'h65, 1'b1};
    send_cmd(6'd2, 32'h0000_0000, RESP_R2, 1'b0, 1'b1, frame, oe_ok);
    card_reply(r2_frame, 136, 1);
    clk1();
    check_value("r2_resp", 136'(hif.response), 136'(r2_payload));
    check_value("r2_resp_top", 136'(hif.response[127:120]), 136'd0);
    clk1();
    errs(e);
    check_value("r2_errs_crc_on", 136'(e), 136'b0100);
    ack_all();
    send_cmd(6'd2, 32'h0000_0000, RESP_R2, 1'b0, 1'b0, frame, oe_ok);
    card_reply(r2_frame, 136, 1);
    repeat (2) clk1();
    errs(e);
    check_value("r2_errs_crc_off", 136'(e), 136'd0);
    check_value("r2_resp2", 136'(hif.response), 136'(r2_payload));
    ack_all();

    // R3: CRC/index never checked, but end bit is
    send_cmd(6'd41, 32'h00FF_8000, RESP_R3, 1'b1, 1'b1, frame, oe_ok);
    card_reply(136'h3F80_FF80_00FE, 48, 3);
    repeat (2) clk1();
    errs(e);
    check_value("r3_errs", 136'(e), 136'b0001);
    check_value("r3_resp", 136'(hif.response), 136'h80FF_8000);
    ack_all();

    // Reset while bit 20 of a command is on the line
    hif.cmd_index    = 6'd17;
    hif.cmd_argument = 32'h1234_5678;
    hif.resp_type    = RESP_48;
    hif.start        = 1'b1;
    clk1();
    hif.start = 1'b0;
    for (int i = 0; i < 21; i++) strobe_period();
    check_value("rst_mid_oe_before", 136'(cmd_oe), 136'd1);
    reset = 1'b1;
    clk1();
    check_value("rst_mid_oe", 136'(cmd_oe), 136'd0);
    check_value("rst_mid_busy", 136'(hif.busy), 136'd0);
    reset = 1'b0;
    clk1();
    send_cmd(6'd8, 32'h0000_01AA, RESP_NONE, 1'b0, 1'b0, frame, oe_ok);
    check_value("post_rst_frame", 136'(frame), 136'h4800_0001_AA87);
    check_value("post_rst_oe_held", 136'(oe_ok), 136'd1);
    clk1();
    check_value("post_rst_cc", 136'(hif.command_complete), 136'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
